// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the program sequencer and its jump LUT.
package prog_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_DEPTH_DEF = 16;

    typedef logic [PC_W_DEF-1:0] pc_t;

endpackage

// File: rtl/jump_lut.sv
// Jump-target LUT: synchronous write, combinational read-before-write.
// Entries beyond LUT_DEPTH read as zero and ignore writes.
module jump_lut
    import prog_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [3:0]      wr_addr,
    input  logic [PC_W-1:0] wr_data,
    input  logic [3:0]      rd_addr,
    output logic [PC_W-1:0] rd_data
);

    localparam int PTR_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    logic [LUT_DEPTH-1:0][PC_W-1:0] mem;

    // Storage: cleared by reset, one entry written per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else if (wr_en && (int'(wr_addr) < LUT_DEPTH)) begin
            mem[wr_addr[PTR_W-1:0]] <= wr_data;
        end
    end

    // Read sees the pre-write contents, so a same-cycle jump uses the old target.
    assign rd_data = (int'(rd_addr) < LUT_DEPTH) ? mem[rd_addr[PTR_W-1:0]] : '0;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, the jump LUT and the start/done handshake.
// Optional macro PROG_SEQ_CYCLE_COUNT_EN adds a saturating RUN-cycle counter
// on output cycle_cnt.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            done,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    input  logic            pc_jmp_en,
    input  logic [3:0]      lut_ptr,
    input  logic            halt,
    input  logic            stall,
`ifdef PROG_SEQ_CYCLE_COUNT_EN
    output logic [31:0]     cycle_cnt,
`endif
    input  logic            lut_wr_en,
    input  logic [3:0]      lut_wr_addr,
    input  logic [PC_W-1:0] lut_wr_data
);

    seq_state_t      state;
    logic [PC_W-1:0] jmp_tgt;

    jump_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_lut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (lut_wr_en),
        .wr_addr (lut_wr_addr),
        .wr_data (lut_wr_data),
        .rd_addr (lut_ptr),
        .rd_data (jmp_tgt)
    );

    // An instruction issues only in RUN while the data memory is ready.
    assign instr_valid = (state == RUN) && !stall;

    // Sequencer FSM; pc and done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= '0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    // stall > halt > jump > increment; start is ignored here.
                    if (stall) begin
                        pc <= pc;
                    end else if (halt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (pc_jmp_en) begin
                        pc <= jmp_tgt;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= '0;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PROG_SEQ_CYCLE_COUNT_EN
    // Counts every RUN cycle (stalls included), saturating; cleared on accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            cycle_cnt <= '0;
        end else if (state == RUN && cycle_cnt != 32'hFFFF_FFFF) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: the driver pushes the expected outputs
// for each cycle, a negedge monitor pops and compares them.
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            reset, start, done, instr_valid, pc_jmp_en, halt, stall;
    logic [PC_W-1:0] pc;
    logic [3:0]      lut_ptr, lut_wr_addr;
    logic            lut_wr_en;
    logic [PC_W-1:0] lut_wr_data;
`ifdef PROG_SEQ_CYCLE_COUNT_EN
    logic [31:0]     cycle_cnt;
`endif

    typedef struct {
        int          id;
        logic [PC_W-1:0] pc;
        logic        vld;
        logic        dn;
        longint      cnt;   // -1: not checked
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step   = 0;

    always #5 clk = ~clk;

    prog_sequencer #(.PC_W(PC_W), .LUT_DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .pc          (pc),
        .instr_valid (instr_valid),
        .pc_jmp_en   (pc_jmp_en),
        .lut_ptr     (lut_ptr),
        .halt        (halt),
        .stall       (stall),
`ifdef PROG_SEQ_CYCLE_COUNT_EN
        .cycle_cnt   (cycle_cnt),
`endif
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data)
    );

    // Advance to just after the next edge and drop all one-cycle controls.
    task automatic nxt();
        @(posedge clk);
        #1;
        start = 0; stall = 0; halt = 0; pc_jmp_en = 0; lut_ptr = 0;
        lut_wr_en = 0; lut_wr_addr = 0; lut_wr_data = 0;
        step++;
    endtask

    task automatic expect_out(input int p, input logic v, input logic d, input longint c = -1);
        exp_t e;
        e.id = step; e.pc = PC_W'(p); e.vld = v; e.dn = d; e.cnt = c;
        q.push_back(e);
    endtask

    task automatic wr(input int a, input int dat);
        lut_wr_en = 1; lut_wr_addr = 4'(a); lut_wr_data = PC_W'(dat);
    endtask

    task automatic jmp(input int p);
        pc_jmp_en = 1; lut_ptr = 4'(p);
    endtask

    // Monitor: compare DUT outputs mid-cycle against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (pc !== e.pc) begin
                    errors++;
                    $display("FAIL step%0d pc: got %0d want %0d", e.id, pc, e.pc);
                end
                checks++;
                if (instr_valid !== e.vld) begin
                    errors++;
                    $display("FAIL step%0d instr_valid: got %b want %b", e.id, instr_valid, e.vld);
                end
                checks++;
                if (done !== e.dn) begin
                    errors++;
                    $display("FAIL step%0d done: got %b want %b", e.id, done, e.dn);
                end
`ifdef PROG_SEQ_CYCLE_COUNT_EN
                if (e.cnt >= 0) begin
                    checks++;
                    if (cycle_cnt !== 32'(e.cnt)) begin
                        errors++;
                        $display("FAIL step%0d cycle_cnt: got %0d want %0d", e.id, cycle_cnt, e.cnt);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Directed stimulus with hand-computed per-cycle outputs.
    initial begin
        reset = 1; start = 0; stall = 0; halt = 0; pc_jmp_en = 0; lut_ptr = 0;
        lut_wr_en = 0; lut_wr_addr = 0; lut_wr_data = 0;

        nxt();            expect_out(0, 0, 0, 0);   // reset state
        nxt(); reset = 0; expect_out(0, 0, 0, 0);
        nxt(); wr(5, 200);  expect_out(0, 0, 0);
        nxt(); wr(3, 20);   expect_out(0, 0, 0);
        nxt(); wr(7, 1022); expect_out(0, 0, 0);
        nxt(); wr(2, 10);   expect_out(0, 0, 0);
        nxt(); wr(4, 9);    expect_out(0, 0, 0);
        nxt(); start = 1;   expect_out(0, 0, 0);
        // RUN from 0: sequential fetch, mid-RUN start ignored
        nxt();            expect_out(0, 1, 0, 0);
        nxt();            expect_out(1, 1, 0);
        nxt();            expect_out(2, 1, 0);
        nxt(); start = 1; expect_out(3, 1, 0);
        nxt();            expect_out(4, 1, 0);
        nxt();            expect_out(5, 1, 0);
        nxt();            expect_out(6, 1, 0);
        nxt(); jmp(5);    expect_out(7, 1, 0);
        nxt(); jmp(2);    expect_out(200, 1, 0);
        nxt();            expect_out(10, 1, 0);
        nxt();            expect_out(11, 1, 0);
        // stall beats halt and jump
        nxt(); stall = 1;                     expect_out(12, 0, 0);
        nxt(); stall = 1; halt = 1; jmp(5);   expect_out(12, 0, 0);
        nxt(); stall = 1; jmp(5);             expect_out(12, 0, 0);
        // halt beats jump
        nxt(); halt = 1; jmp(5);              expect_out(12, 1, 0);
        nxt();            expect_out(12, 0, 1, 15);
        nxt();            expect_out(12, 0, 1, 15);
        nxt(); start = 1; expect_out(12, 0, 1, 15);
        // restart from DONE, then wrap 1023 -> 0
        nxt(); jmp(7);    expect_out(0, 1, 0, 0);
        nxt();            expect_out(1022, 1, 0);
        nxt();            expect_out(1023, 1, 0);
        nxt();            expect_out(0, 1, 0);
        // same-entry write and jump: old target used, new one next time
        nxt(); jmp(3); wr(3, 50); expect_out(1, 1, 0);
        nxt(); jmp(3);    expect_out(20, 1, 0);
        nxt(); jmp(4);    expect_out(50, 1, 0);
        // reset mid-RUN
        nxt(); reset = 1; expect_out(9, 1, 0, 7);
        nxt(); reset = 0; expect_out(0, 0, 0, 0);
        nxt(); start = 1; expect_out(0, 0, 0, 0);
        // LUT entries cleared: jumps land on 0
        nxt(); jmp(5);    expect_out(0, 1, 0, 0);
        nxt(); jmp(3);    expect_out(0, 1, 0);
        nxt();            expect_out(0, 1, 0);
        nxt(); halt = 1;  expect_out(1, 1, 0);
        nxt(); start = 1; expect_out(1, 0, 1);
        nxt();            expect_out(0, 1, 0, 0);
        nxt();            expect_out(1, 1, 0);

        nxt();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
